des_key_sched: RTL and testbench
================================

Name: des_key_sched

Overview:
- Sequential DES key-schedule controller.
- Accepts one 64-bit key and applies PC-1 once. It then steps the 56-bit C/D register through the 16 round rotations and drives the existing key_pc2 block (instantiated inside) to emit subkeys K1..K16 one at a time.
- Output is a valid/ready stream consumed by the round datapath.

Parameters:
- SHIFT_MASK, 16'h8103, bit r-1 = 1 means round r rotates by 1 position; 0 means rotate by 2. The default gives the FIPS 46-3 schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_in  in  64  DES key; key_in[63] = DES bit 1 (standard hex order), parity bits ignored
- key_valid  in  1  key_in is offered
- key_ready  out  1  controller idle and able to accept a key
- mode  in  1  0 = encrypt order, 1 = decrypt order (see Optional Feature)
- subkey  out  48  round subkey; subkey[47] = DES subkey bit 1
- round  out  4  round number of the current subkey, 1..16 encoded as 0..15
- subkey_valid  out  1  subkey, round and last are valid
- subkey_ready  in  1  consumer accepts the current subkey
- last  out  1  high with the final subkey of the key
- busy  out  1  high from key acceptance until the final subkey is accepted

Behaviour:
- C/D register cd[55:0] uses key_pc2 input numbering: cd[i] = DES C/D bit i+1. C = cd[27:0], D = cd[55:28]; cd[0] is C bit 1, cd[28] is D bit 1.
- PC-1 is the standard FIPS 46-3 table: cd[i] = key_in[64 - PC1[i+1]].
- DES left-rotate by n, per 28-bit half h (h[0] = DES bit 1): new h[k] = old h[(k+n) mod 28]. Right-rotate: new h[k] = old h[(k-n) mod 28].
- subkey = key_pc2(cd), combinational from the register. The register changes only on load or acceptance, so subkey is stable while valid.
- FSM states:
  - IDLE: key_ready = 1.
    - On key_valid: cd <= PC1 with round-1 rotation folded in; round <= 0; go to EMIT.
    - Latency: key accepted at edge t gives subkey_valid = 1 after edge t.
  - EMIT: subkey_valid = 1, key_ready = 0.
    - On subkey_valid & subkey_ready with round != 15: rotate cd by SHIFT_MASK[round+1] amount; round <= round + 1. Result is one subkey per cycle under continuous ready.
    - On acceptance with round == 15: go to IDLE, subkey_valid = 0, key_ready = 1 on the next cycle. A new key may be accepted that cycle, so there is one bubble between keys.
- last = subkey_valid & (round == 15).
- busy = state == EMIT.
- Backpressure: subkey_ready low holds subkey, round, last and cd unchanged indefinitely.
- key_valid in EMIT is ignored; key_ready = 0, so there is no handshake and the key is not captured.
- mode is sampled only at key acceptance and held in a register for the whole key.
- Reset values: state IDLE, cd 0, round 0, subkey_valid 0, last 0, busy 0, key_ready 0 during reset and 1 on the first cycle after. subkey equals key_pc2(0) = 0.
- Reset mid-stream: the key is abandoned, no further subkeys are emitted, and the stream is not completed.

Optional Feature:
- Macro DES_KEY_SCHED_DECRYPT_EN.
- Defined, with mode = 1 at acceptance:
  - Load cd <= PC1 with no rotation (C16/D16 = C0/D0); round <= 15. First subkey is K16.
  - Each acceptance with round != 0: right-rotate cd by SHIFT_MASK[round] amount, then round <= round - 1.
  - last when round == 0.
- Undefined: mode is ignored and treated as 0; decrypt logic is not synthesised; the port remains for interface stability.

Test Plan:
- Reset, then key_in = 64'h133457799BBCDFF1 with key_valid, subkey_ready held 1 -> subkey_valid the cycle after acceptance. subkey = 48'h1B02EFFC7072 at round 0 and 48'hCB3D8B0E17F5 with last = 1 at round 15. Exactly 16 consecutive valid cycles, then key_ready = 1.
- Same key, subkey_ready toggled pseudo-randomly -> subkey/round held while ready is low. Accepted sequence identical to test 1, with no drops or duplicates.
- key_valid pulsed while busy with key 64'h0 -> ignored; the in-flight subkey sequence is unchanged.
- rst asserted during round 7, then key 64'h0000000000000000 offered -> after reset subkey_valid = 0 and key_ready = 1. New stream gives all 16 subkeys = 48'h0.
- With DES_KEY_SCHED_DECRYPT_EN and mode = 1, key 64'h133457799BBCDFF1 -> first subkey 48'hCB3D8B0E17F5 (round 15). Last subkey 48'h1B02EFFC7072 (round 0, last = 1). The 16 subkeys are the exact reverse of test 1.
- Back-to-back keys, second key offered while the first stream ends -> second key accepted on the first cycle key_ready = 1. Its first subkey appears one cycle later.

Source files
------------

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: PC-1 once, then one C/D rotation per accepted subkey.
// Optional reverse (decrypt) order enabled by `define DES_KEY_SCHED_DECRYPT_EN.
module key_pc2 (
  input  logic [55:0] cd,
  output logic [47:0] subkey
);
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  always_comb begin
    subkey = '0;
    for (int j = 0; j < 48; j++) subkey[47-j] = cd[PC2[j]-1];
  end
endmodule

module des_key_sched #(
  parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        mode,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        last,
  output logic        busy
);
  typedef enum logic {IDLE, EMIT} state_e;

  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] pc1_key;
  logic        load_dec;
  logic        dec_q, dec_d;
  logic [3:0]  final_round;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] p;
    p = '0;
    for (int i = 0; i < 56; i++) p[i] = k[64-PC1[i]];
    return p;
  endfunction

  // h[0] is DES bit 1, so a DES left rotate moves bits toward index 0.
  function automatic logic [27:0] rot_half(input logic [27:0] h, input logic one,
                                           input logic right);
    if (right) return one ? {h[26:0], h[27]}   : {h[25:0], h[27:26]};
    else       return one ? {h[0],    h[27:1]} : {h[1:0],  h[27:2]};
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] c, input logic one,
                                         input logic right);
    return {rot_half(c[55:28], one, right), rot_half(c[27:0], one, right)};
  endfunction

`ifdef DES_KEY_SCHED_DECRYPT_EN
  assign load_dec = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign load_dec    = 1'b0;
`endif

  assign pc1_key     = pc1(key_in);
  assign final_round = dec_q ? 4'd0 : 4'd15;

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: if (key_valid && key_ready) begin
        state_d = EMIT;
        dec_d   = load_dec;
        if (load_dec) begin
          cd_d    = pc1_key;
          round_d = 4'd15;
        end else begin
          cd_d    = rot_cd(pc1_key, SHIFT_MASK[0], 1'b0);
          round_d = 4'd0;
        end
      end
      EMIT: if (subkey_ready) begin
        if (round_q == final_round) begin
          state_d = IDLE;
        end else if (dec_q) begin
          cd_d    = rot_cd(cd_q, SHIFT_MASK[round_q], 1'b1);
          round_d = round_q - 4'd1;
        end else begin
          cd_d    = rot_cd(cd_q, SHIFT_MASK[round_q + 4'd1], 1'b0);
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  key_pc2 u_pc2 (.cd(cd_q), .subkey(subkey));

  assign subkey_valid = (state_q == EMIT);
  assign busy         = (state_q == EMIT);
  assign key_ready    = (state_q == IDLE) && !rst;
  assign round        = round_q;
  assign last         = subkey_valid && (round_q == final_round);
endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched; reference schedule built from cumulative
// rotations of PC-1 in DES bit numbering.
module tb_des_key_sched;
`ifdef DES_KEY_SCHED_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int PC1T [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                               10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                               63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                               14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2T [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                               23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                               41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                               44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic        clk = 1'b0;
  logic        rst, key_valid, key_ready, mode, subkey_valid, subkey_ready, last, busy;
  logic [63:0] key_in;
  logic [47:0] subkey;
  logic [3:0]  round;

  des_key_sched dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .mode(mode), .subkey(subkey), .round(round), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [47:0] sk; logic [3:0] rnd; logic lst;} exp_t;
  exp_t        sb[$];
  logic [47:0] acc_log[$];
  logic [47:0] t1_log[$];
  logic [47:0] ref_ks [16];
  int          checks = 0, errors = 0, vld_cycles = 0, ready_mode = 0;
  logic        acc_bubble;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // K_r uses C_0/D_0 left-rotated by the running total of shifts up to round r.
  task automatic build_ref(input logic [63:0] key);
    bit kb [1:64];
    bit c0 [1:56];
    bit cr [1:56];
    int s = 0;
    for (int i = 1; i <= 64; i++) kb[i] = key[64-i];
    for (int i = 1; i <= 56; i++) c0[i] = kb[PC1T[i-1]];
    for (int r = 0; r < 16; r++) begin
      s += SHIFTS[r];
      for (int k = 1; k <= 28; k++) begin
        cr[k]    = c0[((k - 1 + s) % 28) + 1];
        cr[28+k] = c0[28 + ((k - 1 + s) % 28) + 1];
      end
      for (int j = 1; j <= 48; j++) ref_ks[r][48-j] = cr[PC2T[j-1]];
    end
  endtask

  task automatic push_expected(input logic [63:0] key, input logic md);
    exp_t e;
    bit   dec = DEC_EN && md;
    build_ref(key);
    for (int i = 0; i < 16; i++) begin
      int r = dec ? 15 - i : i;
      e.sk  = ref_ks[r];
      e.rnd = 4'(r);
      e.lst = dec ? (r == 0) : (r == 15);
      sb.push_back(e);
    end
  endtask

  initial begin
    subkey_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       subkey_ready = 1'b1;
        1:       subkey_ready = 1'($urandom_range(0, 1));
        default: subkey_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on each handshake, and checks outputs hold across stalls.
  initial begin
    logic        stall_prev = 1'b0;
    logic [47:0] h_sk;
    logic [3:0]  h_rnd;
    logic        h_lst;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          chk("hold_subkey", 64'(subkey), 64'(h_sk));
          chk("hold_round", 64'(round), 64'(h_rnd));
          chk("hold_last", 64'(last), 64'(h_lst));
        end
        if (subkey_valid) vld_cycles++;
        chk("busy_vs_valid", 64'(busy), 64'(subkey_valid));
        if (subkey_valid && subkey_ready) begin
          if (sb.size() == 0) chk("unexpected_subkey", 64'(subkey), 64'hx);
          else begin
            e = sb.pop_front();
            chk("subkey", 64'(subkey), 64'(e.sk));
            chk("round", 64'(round), 64'(e.rnd));
            chk("last", 64'(last), 64'(e.lst));
          end
          acc_log.push_back(subkey);
        end
        stall_prev = subkey_valid && !subkey_ready;
        h_sk = subkey; h_rnd = round; h_lst = last;
      end
    end
  end

  task automatic offer_key(input logic [63:0] key, input logic md);
    bit got = 0;
    key_in = key; mode = md; key_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (key_ready) begin
        got = 1;
        acc_bubble = subkey_valid;
        push_expected(key, md);
      end
    end
    if (!got) chk("key_accept_timeout", 64'(key_ready), 64'd1);
    @(posedge clk); #1 key_valid = 1'b0;
    if (got) begin
      @(negedge clk);
      chk("first_valid_latency", 64'(subkey_valid), 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (key_ready && sb.size() == 0) done = 1;
    end
    chk("idle_reached", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic cmp_log(input string name, input bit rev);
    chk({name, "_count"}, 64'(acc_log.size()), 64'd16);
    if (acc_log.size() == 16 && t1_log.size() == 16)
      for (int i = 0; i < 16; i++)
        chk(name, 64'(acc_log[i]), 64'(t1_log[rev ? 15 - i : i]));
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_in = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_key_ready", 64'(key_ready), 64'd0);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_key_ready", 64'(key_ready), 64'd1);
    @(posedge clk); #1;

    // Known-answer stream under continuous ready
    acc_log.delete(); vld_cycles = 0;
    offer_key(KEY_A, 1'b0);
    wait_idle();
    chk("t1_valid_cycles", 64'(vld_cycles), 64'd16);
    chk("t1_key_ready", 64'(key_ready), 64'd1);
    chk("t1_count", 64'(acc_log.size()), 64'd16);
    if (acc_log.size() == 16) begin
      chk("t1_k1", 64'(acc_log[0]), 64'(K1_A));
      chk("t1_k16", 64'(acc_log[15]), 64'(K16_A));
    end
    t1_log = acc_log;

    // Random backpressure
    acc_log.delete(); ready_mode = 1;
    offer_key(KEY_A, 1'b0);
    wait_idle();
    ready_mode = 0;
    cmp_log("t2_seq", 1'b0);

    // Key offered while busy is ignored
    acc_log.delete();
    offer_key(KEY_A, 1'b0);
    key_in = '0; key_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    key_valid = 1'b0;
    wait_idle();
    cmp_log("t3_seq", 1'b0);

    // Decrypt order (encrypt order when the feature is compiled out)
    acc_log.delete();
    offer_key(KEY_A, 1'b1);
    wait_idle();
    cmp_log("t5_seq", DEC_EN);

    // Back-to-back keys: second held valid across the end of the first stream
    acc_log.delete();
    offer_key({$urandom, $urandom}, 1'b0);
    offer_key({$urandom, $urandom}, 1'b1);
    chk("b2b_bubble", 64'(acc_bubble), 64'd0);
    wait_idle();
    chk("b2b_count", 64'(acc_log.size()), 64'd32);

    // Random keys, modes and backpressure
    for (int n = 0; n < 6; n++) begin
      ready_mode = int'($urandom_range(0, 1));
      offer_key({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      wait_idle();
    end
    ready_mode = 0;

    // Reset mid-stream, then an all-zero key
    key_in = {$urandom, $urandom}; mode = 1'b0; key_valid = 1'b1;
    begin
      bit hit = 0;
      bit pushed = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(negedge clk);
        if (key_ready && !pushed) begin push_expected(key_in, 1'b0); pushed = 1; end
        if (subkey_valid && round == 4'd7) hit = 1;
        @(posedge clk); #1 key_valid = 1'b0;
      end
      chk("reach_round7", 64'(hit), 64'd1);
    end
    rst = 1'b1; ready_mode = 2;
    sb.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; ready_mode = 0;
    @(negedge clk);
    chk("midrst_valid", 64'(subkey_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valid2", 64'(subkey_valid), 64'd0);
    chk("midrst_key_ready", 64'(key_ready), 64'd1);
    @(posedge clk); #1;
    acc_log.delete();
    offer_key(64'h0, 1'b0);
    wait_idle();
    chk("zero_count", 64'(acc_log.size()), 64'd16);
    foreach (acc_log[i]) chk("zero_subkey", 64'(acc_log[i]), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
